qwac_mvm_engine: RTL

QWAC_MVM_ENGINE -- requirements
Module: qwac_mvm_engine

---
 rtl/qwac_mvm_engine.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/qwac_mvm_engine.sv
// Matrix-vector multiply engine: TE vectors multiplied by one MAT_R x MAT_C matrix.
// The engine loads its stores word by word, runs one MAC per lane per cycle, then
// streams the results lane-major over a valid/ready handshake.
module qwac_mvm_engine #(
  parameter int unsigned BITS  = 8,
  parameter int unsigned MAT_R = 8,
  parameter int unsigned MAT_C = 4,
  parameter int unsigned TE    = 2,
  parameter int unsigned SAT   = 0,
  localparam int unsigned ACC_BITS = 2 * BITS + $clog2(MAT_C),
  localparam int unsigned MN       = MAT_R * MAT_C,
  localparam int unsigned VN       = TE * MAT_C,
  localparam int unsigned AW       = ($clog2((MN > VN) ? MN : VN) > 0) ?
                                     $clog2((MN > VN) ? MN : VN) : 1,
  localparam int unsigned LW       = (TE > 1) ? $clog2(TE) : 1,
  localparam int unsigned RW       = (MAT_R > 1) ? $clog2(MAT_R) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic                       ld_sel,
  input  logic [AW-1:0]              ld_addr,
  input  logic signed [BITS-1:0]     ld_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_BITS-1:0] out_data,
  output logic [LW-1:0]              out_lane,
  output logic [RW-1:0]              out_row,
  output logic                       out_sat,
  output logic [15:0]                cycle_count
);

  localparam int unsigned RN  = TE * MAT_R;
  localparam int unsigned CW  = (MAT_C > 1) ? $clog2(MAT_C) : 1;
  localparam int unsigned MIW = (MN > 1) ? $clog2(MN) : 1;
  localparam int unsigned VIW = (VN > 1) ? $clog2(VN) : 1;
  localparam int unsigned RIW = (RN > 1) ? $clog2(RN) : 1;

  localparam logic signed [ACC_BITS-1:0] SAT_MAX = ACC_BITS'((2 ** (BITS - 1)) - 1);
  localparam logic signed [ACC_BITS-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_OUTPUT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [RW-1:0]  r_q, r_d;
  logic [CW-1:0]  c_q, c_d;
  logic [15:0]    cycle_count_q, cycle_count_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ld_ready_q, ld_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           out_sat_q, out_sat_d;
  logic signed [ACC_BITS-1:0] out_data_q, out_data_d;
  logic [LW-1:0]  out_lane_q, out_lane_d;
  logic [RW-1:0]  out_row_q, out_row_d;

  logic           mat_we, vec_we, res_we;
  logic           load_word;
  logic [LW-1:0]  fetch_lane;
  logic [RW-1:0]  fetch_row;
  logic signed [ACC_BITS-1:0] fetch_word;

  // Storage: not reset, contents undefined until loaded
  logic signed [BITS-1:0]     mat_mem [MN];
  logic signed [BITS-1:0]     vec_mem [VN];
  logic signed [ACC_BITS-1:0] res_mem [RN];

  logic signed [BITS-1:0]     mat_elem;
  logic signed [BITS-1:0]     vec_elem [TE];
  logic signed [ACC_BITS-1:0] acc_base [TE];
  logic signed [ACC_BITS-1:0] prod     [TE];
  logic signed [ACC_BITS-1:0] acc_sum  [TE];
  logic signed [ACC_BITS-1:0] acc_q    [TE];
  logic signed [ACC_BITS-1:0] acc_d    [TE];

  // MAC datapath: shared matrix element against each lane's vector element
  always_comb begin
    mat_elem = mat_mem[MIW'(32'(r_q) * MAT_C + 32'(c_q))];
    for (int unsigned t = 0; t < TE; t++) begin
      vec_elem[t] = vec_mem[VIW'(32'(t) * MAT_C + 32'(c_q))];
      if (c_q == '0) begin
        acc_base[t] = '0;
      end else begin
        acc_base[t] = acc_q[t];
      end
      prod[t]    = ACC_BITS'(mat_elem) * ACC_BITS'(vec_elem[t]);
      acc_sum[t] = acc_base[t] + prod[t];
      acc_d[t]   = (state_q == S_COMPUTE) ? acc_sum[t] : acc_q[t];
    end
  end

  // Control FSM: sequencing, load acceptance, handshake and run counter
  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    c_d           = c_q;
    cycle_count_d = cycle_count_q;
    out_valid_d   = out_valid_q;
    done_d        = 1'b0;
    mat_we        = 1'b0;
    vec_we        = 1'b0;
    res_we        = 1'b0;
    load_word     = 1'b0;
    fetch_lane    = '0;
    fetch_row     = '0;

    if (state_q != S_IDLE && cycle_count_q != 16'hFFFF) begin
      cycle_count_d = cycle_count_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (ld_valid) begin
          mat_we = !ld_sel && (32'(ld_addr) < MN);
          vec_we = ld_sel && (32'(ld_addr) < VN);
        end
        if (start) begin
          state_d       = S_COMPUTE;
          r_d           = '0;
          c_d           = '0;
          cycle_count_d = 16'd0;
        end
      end
      S_COMPUTE: begin
        if (c_q == CW'(MAT_C - 1)) begin
          res_we = 1'b1;
          c_d    = '0;
          if (r_q == RW'(MAT_R - 1)) begin
            state_d     = S_OUTPUT;
            out_valid_d = 1'b1;
            load_word   = 1'b1;
          end else begin
            r_d = r_q + RW'(1);
          end
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          if (out_lane_q == LW'(TE - 1) && out_row_q == RW'(MAT_R - 1)) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            load_word = 1'b1;
            if (out_row_q == RW'(MAT_R - 1)) begin
              fetch_lane = out_lane_q + LW'(1);
              fetch_row  = '0;
            end else begin
              fetch_lane = out_lane_q;
              fetch_row  = out_row_q + RW'(1);
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ld_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  // Result word fetch; bypasses the row being written on the final MAC cycle
  always_comb begin
    fetch_word = res_mem[RIW'(32'(fetch_lane) * MAT_R + 32'(fetch_row))];
    if (res_we && fetch_row == r_q) begin
      fetch_word = acc_sum[fetch_lane];
    end
  end

  // Output word register with optional clipping to the element range
  always_comb begin
    out_data_d = out_data_q;
    out_lane_d = out_lane_q;
    out_row_d  = out_row_q;
    out_sat_d  = out_sat_q;
    if (load_word) begin
      out_lane_d = fetch_lane;
      out_row_d  = fetch_row;
      out_data_d = fetch_word;
      out_sat_d  = 1'b0;
      if (SAT == 1) begin
        if (fetch_word > SAT_MAX) begin
          out_data_d = SAT_MAX;
          out_sat_d  = 1'b1;
        end else if (fetch_word < SAT_MIN) begin
          out_data_d = SAT_MIN;
          out_sat_d  = 1'b1;
        end
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      r_q           <= '0;
      c_q           <= '0;
      cycle_count_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ld_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_sat_q     <= 1'b0;
      out_data_q    <= '0;
      out_lane_q    <= '0;
      out_row_q     <= '0;
      for (int unsigned t = 0; t < TE; t++) begin
        acc_q[t] <= '0;
      end
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      c_q           <= c_d;
      cycle_count_q <= cycle_count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ld_ready_q    <= ld_ready_d;
      out_valid_q   <= out_valid_d;
      out_sat_q     <= out_sat_d;
      out_data_q    <= out_data_d;
      out_lane_q    <= out_lane_d;
      out_row_q     <= out_row_d;
      for (int unsigned t = 0; t < TE; t++) begin
        acc_q[t] <= acc_d[t];
      end
    end
  end

  // Matrix, vector and result stores
  always_ff @(posedge clock) begin
    if (mat_we) begin
      mat_mem[MIW'(ld_addr)] <= ld_data;
    end
    if (vec_we) begin
      vec_mem[VIW'(ld_addr)] <= ld_data;
    end
    if (res_we) begin
      for (int unsigned t = 0; t < TE; t++) begin
        res_mem[RIW'(32'(t) * MAT_R + 32'(r_q))] <= acc_sum[t];
      end
    end
  end

  assign ld_ready    = ld_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_lane    = out_lane_q;
  assign out_row     = out_row_q;
  assign out_sat     = out_sat_q;
  assign cycle_count = cycle_count_q;

endmodule
